// File: rtl/pll_lock_sequencer_pkg.sv
// Shared clock/reset definitions for the core clock domain: sequencer state
// encoding and default clock/audio-rate constants.
package pll_lock_sequencer_pkg;

    localparam int unsigned CORE_CLK_HZ    = 30_000_000;
    localparam int unsigned AUDIO_FRAC_NUM = 63;
    localparam int unsigned AUDIO_FRAC_DEN = 50_000;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

    // Nominal strobe rate of a fractional enable running off the core clock.
    function automatic int unsigned frac_ce_hz(input int unsigned num, input int unsigned den);
        return int'((longint'(CORE_CLK_HZ) * longint'(num)) / longint'(den));
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_frac_ce_gen.sv
// Fractional clock-enable generator: emits NUM single-cycle strobes per DEN
// cycles of 'run', evenly spread by a wrap-around accumulator.
module frac_ce_gen
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned NUM = AUDIO_FRAC_NUM,
    parameter int unsigned DEN = AUDIO_FRAC_DEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic ce
);

    // acc < DEN and NUM < DEN, so acc+NUM < 2*DEN fits in ACC_W bits.
    localparam int unsigned ACC_W = $clog2(DEN) + 1;
    localparam logic [ACC_W-1:0] NUM_V = ACC_W'(NUM);
    localparam logic [ACC_W-1:0] DEN_V = ACC_W'(DEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum = acc + NUM_V;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order the statements appear in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (!run) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (sum >= DEN_V) begin
            acc <= sum - DEN_V;
            ce  <= 1'b1;
        end else begin
            acc <= sum;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: synchronises pll_locked, holds core_reset until lock has
// qualified plus HOLD_CYCLES, and issues CPU (clk/2) and fractional audio enables.
// Optional build macro: LOCK_DEBOUNCE_EN adds a DEBOUNCE_CYCLES lock filter.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 256,
    parameter int unsigned FRAC_NUM        = AUDIO_FRAC_NUM,
    parameter int unsigned FRAC_DEN        = AUDIO_FRAC_DEN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       ext_reset_req,
    output logic       core_reset,
    output logic       ce_cpu,
    output logic       ce_frac,
    output logic [1:0] seq_state
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic              sync_meta;
    logic              lk;
    logic              lock_qualified;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_load;
    logic              hold_dec;
    logic              run_next;
    logic              cpu_toggle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            lk        <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            lk        <= sync_meta;
        end
    end

`ifdef LOCK_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);

    logic [DEB_W-1:0] deb_cnt;

    // Counts consecutive lk=1 cycles in WAIT_LOCK; saturates at DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
        end else if ((state != WAIT_LOCK) || !lk) begin
            deb_cnt <= '0;
        end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign lock_qualified = lk && (deb_cnt == DEB_MAX);
`else
    assign lock_qualified = lk;

    // DEBOUNCE_CYCLES only shapes hardware when the lock filter is built in.
    if (DEBOUNCE_CYCLES == 0) begin : g_debounce_unused
    end
`endif

    // Lock loss is tested first in every state so it outranks ext_reset_req.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_qualified) begin
                    next_state = HOLD;
                    hold_load  = 1'b1;
                end
            end
            HOLD: begin
                if (!lk) begin
                    next_state = WAIT_LOCK;
                end else if (ext_reset_req) begin
                    hold_load = 1'b1;
                end else if (hold_cnt == '0) begin
                    next_state = RUN;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    next_state = WAIT_LOCK;
                end else if (ext_reset_req) begin
                    next_state = HOLD;
                    hold_load  = 1'b1;
                end
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    assign run_next = (next_state == RUN);

    // Outputs are registered from next_state: core_reset falls on the edge that
    // enters RUN, and both enables drop on the edge core_reset rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            ce_cpu     <= 1'b0;
            cpu_toggle <= 1'b0;
        end else begin
            state      <= next_state;
            core_reset <= !run_next;
            if (hold_load) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (run_next) begin
                ce_cpu     <= !cpu_toggle;
                cpu_toggle <= !cpu_toggle;
            end else begin
                ce_cpu     <= 1'b0;
                cpu_toggle <= 1'b0;
            end
        end
    end

    assign seq_state = state;

    frac_ce_gen #(
        .NUM (FRAC_NUM),
        .DEN (FRAC_DEN)
    ) u_frac_ce (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run_next),
        .ce      (ce_frac)
    );

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus random
// lock/request traffic, all compared against an event-time reference model.
module tb_pll_lock_sequencer;
    import pll_lock_sequencer_pkg::*;

    localparam int unsigned H  = 16;
    localparam int unsigned DB = 8;
    localparam int unsigned FN = AUDIO_FRAC_NUM;
    localparam int unsigned FD = AUDIO_FRAC_DEN;
`ifdef LOCK_DEBOUNCE_EN
    localparam longint ENTRY_EXTRA = DB;
`else
    localparam longint ENTRY_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       ext_reset_req;
    logic       core_reset;
    logic       ce_cpu;
    logic       ce_frac;
    logic [1:0] seq_state;

    int vectors;
    int miscompares;

    // Reference model: edge index, last edge that saw lk=0, last honoured request.
    longint     t;
    longint     last_low;
    longint     last_ext;
    logic       d1, d2;
    logic       exp_cr, exp_cpu, exp_frac;
    logic [1:0] exp_st;

    pll_lock_sequencer #(
        .HOLD_CYCLES     (H),
        .DEBOUNCE_CYCLES (DB),
        .FRAC_NUM        (FN),
        .FRAC_DEN        (FD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .ext_reset_req (ext_reset_req),
        .core_reset    (core_reset),
        .ce_cpu        (ce_cpu),
        .ce_frac       (ce_frac),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        d1       = 1'b0;
        d2       = 1'b0;
        last_low = t;
        last_ext = -1;
    endtask

    // Outputs after edge t follow from timing alone: the hold counter was last
    // loaded at the later of HOLD entry and the last request, RUN begins H edges later.
    task automatic model_edge(input logic p, input logic e);
        longint hold_entry, load, k;
        logic   lk_seen;
        lk_seen = d2;
        d2      = d1;
        d1      = p;
        if (!lk_seen) last_low = t;
        hold_entry = last_low + 1 + ENTRY_EXTRA;
        if (lk_seen && e && t >= hold_entry) last_ext = t;
        load     = (last_ext >= hold_entry) ? last_ext : hold_entry;
        exp_cr   = 1'b1;
        exp_cpu  = 1'b0;
        exp_frac = 1'b0;
        if (!lk_seen || t < hold_entry) begin
            exp_st = 2'd0;
        end else if (t < load + H) begin
            exp_st = 2'd1;
        end else begin
            exp_st   = 2'd2;
            exp_cr   = 1'b0;
            k        = t - (load + H);
            exp_cpu  = (k % 2 == 0);
            exp_frac = (((k + 1) * FN) / FD) != ((k * FN) / FD);
        end
        t++;
    endtask

    // Called at a falling edge: drive, clock once, compare at the next falling edge.
    task automatic step(input logic p, input logic e);
        pll_locked    = p;
        ext_reset_req = e;
        @(posedge clk);
        model_edge(p, e);
        @(negedge clk);
        vectors++;
        if ({core_reset, ce_cpu, ce_frac, seq_state} !== {exp_cr, exp_cpu, exp_frac, exp_st}) begin
            miscompares++;
            $display("FAIL model edge %0d: got rst=%b cpu=%b frac=%b st=%0d, want rst=%b cpu=%b frac=%b st=%0d",
                     t - 1, core_reset, ce_cpu, ce_frac, seq_state, exp_cr, exp_cpu, exp_frac, exp_st);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({core_reset, ce_cpu, ce_frac, seq_state} !== 5'b1_0_0_00) begin
            miscompares++;
            $display("FAIL reset_values: got %b, want 10000", {core_reset, ce_cpu, ce_frac, seq_state});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (4) step(1'b0, 1'b0);
    endtask

    task automatic test_lock_latency();
        int   fall_edge = -1;
        logic cpu_at [1:40];
        for (int n = 1; n <= 40; n++) begin
            step(1'b1, 1'b0);
            if (fall_edge < 0 && core_reset === 1'b0) fall_edge = n;
            cpu_at[n] = ce_cpu;
        end
        vectors++;
        if (fall_edge != int'(3 + ENTRY_EXTRA + H)) begin
            miscompares++;
            $display("FAIL lock_latency: core_reset fell at edge %0d, want %0d", fall_edge, 3 + ENTRY_EXTRA + H);
        end
        for (int j = 0; j < 5; j++) begin
            vectors++;
            if (cpu_at[3 + ENTRY_EXTRA + H + j] !== ((j % 2) == 0)) begin
                miscompares++;
                $display("FAIL ce_cpu_phase: RUN cycle %0d got %b, want %b", j, cpu_at[3 + ENTRY_EXTRA + H + j], (j % 2) == 0);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic cr2, cr3, ces3;
        int   back = -1;
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0);
            if (i == 2) cr2 = core_reset;
            if (i == 3) begin
                cr3  = core_reset;
                ces3 = ce_cpu | ce_frac;
            end
        end
        vectors++;
        if ({cr2, cr3, ces3} !== 3'b010) begin
            miscompares++;
            $display("FAIL lock_loss_edge: rst@2=%b rst@3=%b ce@3=%b, want 0 1 0", cr2, cr3, ces3);
        end
        for (int i = 4; i <= 60; i++) begin
            step(1'b1, 1'b0);
            if (back < 0 && core_reset === 1'b0) back = i;
        end
        vectors++;
        if (back != int'(6 + ENTRY_EXTRA + H)) begin
            miscompares++;
            $display("FAIL relock_hold: RUN re-entered at edge %0d, want %0d", back, 6 + ENTRY_EXTRA + H);
        end
    endtask

    task automatic test_ext_request();
        int high_cnt = 0;
        int st_bad   = 0;
        int guard    = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            if (core_reset === 1'b1) high_cnt++;
            if (seq_state !== 2'd1) st_bad++;
        end
        while (core_reset === 1'b1 && guard < 60) begin
            step(1'b1, 1'b0);
            if (core_reset === 1'b1) begin
                high_cnt++;
                if (seq_state !== 2'd1) st_bad++;
            end
            guard++;
        end
        // The first request edge already enters HOLD with a load, so the
        // four later request edges plus one full hold make up the reset time.
        vectors++;
        if (high_cnt != int'(4 + H)) begin
            miscompares++;
            $display("FAIL ext_request_len: core_reset high %0d cycles, want %0d", high_cnt, 4 + H);
        end
        vectors++;
        if (st_bad != 0) begin
            miscompares++;
            $display("FAIL ext_request_state: %0d reset cycles not in HOLD, want 0", st_bad);
        end
    endtask

    task automatic test_frac_rate();
        int   run_idx  = 0;
        int   pulses   = 0;
        int   first    = -1;
        int   adjacent = 0;
        int   guard    = 0;
        logic prev     = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        while (run_idx < int'(FD) && guard < int'(FD) + 200) begin
            step(1'b1, 1'b0);
            guard++;
            if (core_reset === 1'b0) begin
                if (ce_frac === 1'b1) begin
                    pulses++;
                    if (first < 0) first = run_idx;
                    if (prev) adjacent++;
                end
                prev = ce_frac;
                run_idx++;
            end
        end
        vectors++;
        if (run_idx != int'(FD)) begin
            miscompares++;
            $display("FAIL frac_timeout: only %0d RUN cycles seen, want %0d", run_idx, FD);
        end
        vectors++;
        if (pulses != int'(FN)) begin
            miscompares++;
            $display("FAIL frac_count: %0d pulses, want %0d", pulses, FN);
        end
        vectors++;
        if (first != int'((FD + FN - 1) / FN) - 1) begin
            miscompares++;
            $display("FAIL frac_first: first pulse at RUN cycle %0d, want %0d", first, int'((FD + FN - 1) / FN) - 1);
        end
        vectors++;
        if (adjacent != 0) begin
            miscompares++;
            $display("FAIL frac_adjacent: %0d back-to-back pulses, want 0", adjacent);
        end
    endtask

    task automatic test_debounce();
        int left_wait = 0;
        int entry     = -1;
        repeat (4) step(1'b0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            repeat (6) begin
                step(1'b1, 1'b0);
                if (seq_state !== 2'd0) left_wait++;
            end
            step(1'b0, 1'b0);
            if (seq_state !== 2'd0) left_wait++;
        end
        vectors++;
`ifdef LOCK_DEBOUNCE_EN
        if (left_wait != 0) begin
            miscompares++;
            $display("FAIL debounce_filter: %0d cycles outside WAIT_LOCK, want 0", left_wait);
        end
`else
        if (left_wait == 0) begin
            miscompares++;
            $display("FAIL no_debounce_entry: 0 cycles outside WAIT_LOCK, want some");
        end
`endif
        repeat (4) step(1'b0, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            step(1'b1, 1'b0);
            if (entry < 0 && seq_state === 2'd1) entry = n;
        end
        vectors++;
        if (entry != int'(3 + ENTRY_EXTRA)) begin
            miscompares++;
            $display("FAIL hold_entry: HOLD at edge %0d, want %0d", entry, 3 + ENTRY_EXTRA);
        end
    endtask

    task automatic test_random();
        logic p, e;
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 99) >= 2);
            e = ($urandom_range(0, 99) < 3);
            step(p, e);
        end
    endtask

    task automatic async_reset_pulse(input string where);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({core_reset, ce_cpu, ce_frac, seq_state} !== 5'b1_0_0_00) begin
            miscompares++;
            $display("FAIL async_reset_%s: got %b, want 10000", where, {core_reset, ce_cpu, ce_frac, seq_state});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_async_reset();
        int guard = 0;
        repeat (3) step(1'b0, 1'b0);
        repeat (8 + ENTRY_EXTRA) step(1'b1, 1'b0);
        async_reset_pulse("hold");
        while (core_reset === 1'b1 && guard < 100) begin
            step(1'b1, 1'b0);
            guard++;
        end
        vectors++;
        if (core_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_timeout: core_reset=%b after %0d cycles, want 0", core_reset, guard);
        end
        repeat (5) step(1'b1, 1'b0);
        async_reset_pulse("run");
        repeat (30 + ENTRY_EXTRA) step(1'b1, 1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        t             = 0;
        reset_n       = 1'b0;
        pll_locked    = 1'b0;
        ext_reset_req = 1'b0;
        model_reset();
        $display("nominal audio enable rate: %0d Hz", frac_ce_hz(FN, FD));
        repeat (2) @(negedge clk);
        test_reset();
        test_lock_latency();
        test_lock_loss();
        test_ext_request();
        test_frac_rate();
        test_debounce();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
